// File: rtl/data_cache_dm.sv
// Direct-mapped write-back, write-allocate data cache between MEM stage and 256-bit block memory.
// Latency: hits respond in the same cycle; clean miss = IDLE+FILL, dirty miss = IDLE+WB+FILL, plus memory wait cycles.
// Backpressure: data_valid_fDC=0 stalls the pipeline; WB/FILL hold dBlkWrite/dBlkRead until the memory valid arrives.
// Ports:
//   CLK, RESET (async active-low)
//   MEM side : data_address_2DC, read_2DC, write_2DC, data_write_2DC, data_write_size_2DC, flush_2DC,
//              data_read_fDC, data_valid_fDC
//   DM side  : data_address_2DM, dBlkRead, block_read_fDM, block_read_fDM_valid,
//              dBlkWrite, block_write_2DM, block_write_fDM_valid
module data_cache_dm #(
  parameter int NUM_LINES  = 32,
  parameter int INDEX_BITS = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DC,
  input  logic         read_2DC,
  input  logic         write_2DC,
  input  logic [31:0]  data_write_2DC,
  input  logic [1:0]   data_write_size_2DC,
  input  logic         flush_2DC,
  output logic [31:0]  data_read_fDC,
  output logic         data_valid_fDC,
  output logic [31:0]  data_address_2DM,
  output logic         dBlkRead,
  input  logic [255:0] block_read_fDM,
  input  logic         block_read_fDM_valid,
  output logic         dBlkWrite,
  output logic [255:0] block_write_2DM,
  input  logic         block_write_fDM_valid
);

  localparam int TAG_BITS = 27 - INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_FL_SCAN, S_FL_WB, S_FL_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_LINES-1:0]  r_valid, r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [NUM_LINES];
  logic [255:0]          r_data [NUM_LINES];
  logic [26:0]           r_miss_blk;     // line address of the outstanding miss
  logic [INDEX_BITS-1:0] r_flush_idx;

  logic [INDEX_BITS-1:0] w_idx, w_miss_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [2:0]            w_word;
  logic                  w_req_acc, w_hit, w_wr_hit;
  logic [31:0]           w_cur_word, w_merged;
  int                    w_k, w_n, w_j;

  assign w_idx      = data_address_2DC[5+INDEX_BITS-1:5];
  assign w_tag      = data_address_2DC[31:5+INDEX_BITS];
  assign w_word     = data_address_2DC[4:2];
  assign w_miss_idx = r_miss_blk[INDEX_BITS-1:0];
  assign w_req_acc  = write_2DC | read_2DC;
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wr_hit   = (r_state == S_IDLE) && !flush_2DC && write_2DC && w_hit;
  assign w_cur_word = r_data[w_idx][{w_word, 5'b0} +: 32];

  // Byte k of a word sits at [31-8k -: 8]; the N store bytes land MSB first starting at k.
  always_comb begin
    w_merged = w_cur_word;
    w_k      = int'(data_address_2DC[1:0]);
    w_n      = (data_write_size_2DC == 2'd0) ? 4 : int'(data_write_size_2DC);
    w_j      = 0;
    for (int i = 0; i < 4; i++) begin
      w_j = i - w_k;
      if (w_j >= 0 && w_j < w_n)
        w_merged[31-8*i -: 8] = data_write_2DC[8*(w_n-1-w_j) +: 8];
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    data_valid_fDC   = 1'b0;
    data_read_fDC    = '0;
    dBlkRead         = 1'b0;
    dBlkWrite        = 1'b0;
    data_address_2DM = '0;
    block_write_2DM  = '0;
    case (r_state)
      S_IDLE: begin
        if (flush_2DC) begin
          w_state_nxt = S_FL_SCAN;
        end else if (w_req_acc) begin
          if (w_hit) begin
            data_valid_fDC = 1'b1;
            if (!write_2DC) data_read_fDC = w_cur_word;
          end else begin
            w_state_nxt = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FILL;
          end
        end else begin
          data_valid_fDC = 1'b1;
        end
      end
      S_WB: begin
        dBlkWrite        = 1'b1;
        data_address_2DM = {r_tag[w_miss_idx], w_miss_idx, 5'b0};
        block_write_2DM  = r_data[w_miss_idx];
        if (block_write_fDM_valid) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        dBlkRead         = 1'b1;
        data_address_2DM = {r_miss_blk, 5'b0};
        if (block_read_fDM_valid) w_state_nxt = S_IDLE;
      end
      S_FL_SCAN: begin
        if (r_valid[r_flush_idx] && r_dirty[r_flush_idx]) w_state_nxt = S_FL_WB;
        else if (r_flush_idx == LAST_IDX)                 w_state_nxt = S_FL_DONE;
      end
      S_FL_WB: begin
        dBlkWrite        = 1'b1;
        data_address_2DM = {r_tag[r_flush_idx], r_flush_idx, 5'b0};
        block_write_2DM  = r_data[r_flush_idx];
        if (block_write_fDM_valid) w_state_nxt = S_FL_SCAN;
      end
      S_FL_DONE: begin
        data_valid_fDC = 1'b1;
        if (!flush_2DC) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_miss_blk  <= '0;
      r_flush_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (flush_2DC) r_flush_idx <= '0;
          else if (w_req_acc && !w_hit) r_miss_blk <= data_address_2DC[31:5];
          if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
        end
        S_WB:
          if (block_write_fDM_valid) r_dirty[w_miss_idx] <= 1'b0;
        S_FILL:
          if (block_read_fDM_valid) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_dirty[w_miss_idx] <= 1'b0;
          end
        S_FL_SCAN:
          // A dirty line is revisited after its writeback, so it is invalidated on the second pass.
          if (!(r_valid[r_flush_idx] && r_dirty[r_flush_idx])) begin
            r_valid[r_flush_idx] <= 1'b0;
            r_flush_idx          <= r_flush_idx + INDEX_BITS'(1);
          end
        S_FL_WB:
          if (block_write_fDM_valid) r_dirty[r_flush_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity is tracked by r_valid alone.
  always_ff @(posedge CLK) begin
    if (w_wr_hit)
      r_data[w_idx][{w_word, 5'b0} +: 32] <= w_merged;
    if (r_state == S_FILL && block_read_fDM_valid) begin
      r_data[w_miss_idx] <= block_read_fDM;
      r_tag[w_miss_idx]  <= r_miss_blk[26:INDEX_BITS];
    end
  end

endmodule

// File: doc/data_cache_dm.md
Name: data_cache_dm

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MEM stage and the data-memory block interface.
- Replaces the pass-through wiring: it consumes MEM-stage word/sub-word requests and produces 256-bit line fills and writebacks on dBlkRead/dBlkWrite.
- Supports a full flush-and-invalidate for syscalls.
- data_valid_fDC stalls the pipeline while a miss or flush is in progress.

Parameters:
- NUM_LINES, 32: number of cache lines; power of two, at least 2.
- INDEX_BITS, 5: log2(NUM_LINES).
- Line size is fixed at 256 bits (8 words), so offset = addr[4:0] and tag = addr[31:5+INDEX_BITS].

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- data_address_2DC  in  32  byte address from MEM.
- read_2DC  in  1  load request.
- write_2DC  in  1  store request.
- data_write_2DC  in  32  store data; the low N bytes are used.
- data_write_size_2DC  in  2  store size: 1, 2 or 3 bytes; 0 means 4 bytes.
- flush_2DC  in  1  flush-and-invalidate request, held until done.
- data_read_fDC  out  32  load data, big-endian word.
- data_valid_fDC  out  1  request satisfied this cycle.
- data_address_2DM  out  32  line-aligned block address (low 5 bits zero).
- dBlkRead  out  1  block read request.
- block_read_fDM  in  256  fill data.
- block_read_fDM_valid  in  1  fill complete.
- dBlkWrite  out  1  block write request.
- block_write_2DM  out  256  victim line data.
- block_write_fDM_valid  in  1  writeback complete.

Behaviour:
- Line layout:
  - Word w (addr[4:2]) occupies line bits [32w+31:32w].
  - Within a word, byte offset k (addr[1:0]) occupies bits [31-8k -: 8].
  - A store of N bytes at offset k writes bytes k..k+N-1 from data_write_2DC[8N-1:0], MSB first.
  - Stores crossing a word boundary are illegal and undefined.
- Reset (RESET=0, async):
  - All valid and dirty bits cleared; state = IDLE.
  - dBlkRead=0, dBlkWrite=0, data_address_2DM=0, data_read_fDC=0.
  - Tag/data arrays need not be reset.
  - Reset mid-writeback or mid-fill aborts the operation at once; dirty data is lost.
- Request priority: flush_2DC, then write_2DC, then read_2DC.
- data_valid_fDC:
  - Driven combinationally.
  - Equals 1 in IDLE when no request is present, or when the request hits.
  - Equals 0 otherwise.
- States: IDLE, WB, FILL, FL_SCAN, FL_WB, FL_DONE.
- IDLE:
  - Read hit: data_read_fDC = selected word in the same cycle, zero latency.
  - Write hit: bytes merged at the clock edge; dirty bit set.
  - Miss: latch the request address into miss_addr.
    - Victim valid and dirty: go to WB.
    - Otherwise: go to FILL.
- WB:
  - dBlkWrite=1, data_address_2DM = {victim tag, index, 5'b0}, block_write_2DM = victim line.
  - Held until block_write_fDM_valid=1.
  - Then clear the dirty bit and go to FILL.
- FILL:
  - dBlkRead=1, data_address_2DM = {miss_addr[31:5], 5'b0}.
  - Held until block_read_fDM_valid=1.
  - Then install the line valid and clean, write the tag, and go to IDLE.
  - The retried access hits on the next cycle; a store then marks the line dirty.
- Miss latency with a 1-cycle memory response:
  - Clean miss: 2 cycles of data_valid_fDC=0.
  - Dirty miss: 3 cycles.
- The request inputs must stay stable while data_valid_fDC=0. If the address changes mid-miss, the fill still completes for miss_addr.
- Flush:
  - From IDLE, flush_2DC=1 goes to FL_SCAN with a line counter at 0.
  - FL_SCAN, current line valid and dirty: go to FL_WB. FL_WB is the same handshake as WB; on completion it returns to FL_SCAN.
  - FL_SCAN, current line not dirty: clear its valid bit and advance the counter, one line per cycle.
  - After the last line (counter wraps at NUM_LINES-1): go to FL_DONE.
  - FL_DONE: data_valid_fDC=1; stay until flush_2DC=0, then go to IDLE.
  - Every line is invalid after a flush.
- dBlkRead and dBlkWrite are never asserted together.
- Valid signals arriving while their request is not asserted are ignored.

Test Plan:
- Reset, then read 0x00001004 with memory line = {W7..W0}, W1=0xDEADBEEF -> data_valid_fDC=0 for 2 cycles, dBlkRead=1 with address 0x00001000, then data_read_fDC=0xDEADBEEF with valid=1; an immediate re-read hits with zero latency.
- Store size 1 of 0xAB at 0x00001005 to the resident line -> next read of 0x00001004 returns 0xDEABBEEF; no memory traffic.
- Read 0x00001404 (same index, NUM_LINES=32) after that store -> dBlkWrite with address 0x00001000 and the modified line, then dBlkRead at 0x00001400, then valid.
- Store of size 0 (4 bytes) 0x11223344 to 0x00002008 on a miss -> fill, then merge; a read returns 0x11223344 and the line is dirty.
- With two dirty lines, hold flush_2DC=1 -> exactly two dBlkWrite handshakes, FL_DONE with valid=1, and all subsequent accesses miss.
- Assert RESET=0 mid-WB -> dBlkWrite drops asynchronously; after release, state is IDLE and the cache is empty.
